// File: rtl/posit_decoder_if.sv
// Operand/result bundle between the posit decoder and the multiplier datapath.
// The master drives the operand and the ack; the slave (decoder) returns the decoded fields.
interface posit_decoder_if #(
    parameter int N         = 32,
    parameter int ES        = 3,
    parameter int K_BITS    = 6,
    parameter int FRAC_BITS = N - ES - 3
);
    logic                 start;
    logic [N-1:0]         posit_in;
    logic                 ready_in;
    logic                 sign_out;
    logic [K_BITS-1:0]    k_out;
    logic [ES-1:0]        exp_out;
    logic [FRAC_BITS-1:0] frac_out;
    logic                 zero_out;
    logic                 NaR;
    logic                 done;

    modport master (
        output start, posit_in, ready_in,
        input  sign_out, k_out, exp_out, frac_out, zero_out, NaR, done
    );

    modport slave (
        input  start, posit_in, ready_in,
        output sign_out, k_out, exp_out, frac_out, zero_out, NaR, done
    );
endinterface

// File: rtl/posit_decoder.sv
// Serial posit field extractor: scans the regime run one bit per clock and presents
// sign, regime k, exponent and MSB-aligned fraction on a done/ready handshake.
module posit_decoder #(
    parameter int N         = 32,
    parameter int ES        = 3,
    parameter int K_BITS    = 6,
    parameter int FRAC_BITS = N - ES - 3
) (
    input logic            clk,
    input logic            rst,
    posit_decoder_if.slave bus
);
    localparam int M_BITS = $clog2(N);
    localparam logic [N-1:0]      NAR_PATTERN = {1'b1, {(N-1){1'b0}}};
    localparam logic [M_BITS-1:0] M_LAST      = M_BITS'(N - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        EXTRACT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_r;
    logic [N-2:0]         body_r;
    logic                 r0_r;
    logic                 sign_r;
    logic [M_BITS-1:0]    m_r;

    logic                 sign_out_r;
    logic [K_BITS-1:0]    k_out_r;
    logic [ES-1:0]        exp_out_r;
    logic [FRAC_BITS-1:0] frac_out_r;
    logic                 zero_out_r;
    logic                 nar_r;
    logic                 done_r;

    logic [N-2:0]         body_in_s;
    logic [K_BITS-1:0]    m_ext_s;
    logic [K_BITS-1:0]    k_s;
    logic                 run_s;

    // Operand magnitude body, regime value from the run length, and run-continue test.
    always_comb begin
        body_in_s = bus.posit_in[N-2:0];
        if (bus.posit_in[N-1]) begin
            // Low N-1 bits of the two's-complement negation; NaR never reaches SCAN.
            body_in_s = {(N-1){1'b0}} - bus.posit_in[N-2:0];
        end else begin
            body_in_s = bus.posit_in[N-2:0];
        end

        m_ext_s = K_BITS'(m_r);
        k_s     = {K_BITS{1'b0}};
        if (r0_r) begin
            k_s = m_ext_s - K_BITS'(1'b1);
        end else begin
            k_s = {K_BITS{1'b0}} - m_ext_s;
        end

        run_s = (body_r[N-2] == r0_r);
    end

    // Decoder FSM with all results registered; outputs only change on entry into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            body_r     <= {(N-1){1'b0}};
            r0_r       <= 1'b0;
            sign_r     <= 1'b0;
            m_r        <= {M_BITS{1'b0}};
            sign_out_r <= 1'b0;
            k_out_r    <= {K_BITS{1'b0}};
            exp_out_r  <= {ES{1'b0}};
            frac_out_r <= {FRAC_BITS{1'b0}};
            zero_out_r <= 1'b0;
            nar_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        sign_r <= bus.posit_in[N-1];
                        body_r <= body_in_s;
                        r0_r   <= body_in_s[N-2];
                        m_r    <= {M_BITS{1'b0}};
                        if (bus.posit_in == {N{1'b0}}) begin
                            sign_out_r <= 1'b0;
                            k_out_r    <= {K_BITS{1'b0}};
                            exp_out_r  <= {ES{1'b0}};
                            frac_out_r <= {FRAC_BITS{1'b0}};
                            zero_out_r <= 1'b1;
                            nar_r      <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= DONE;
                        end else if (bus.posit_in == NAR_PATTERN) begin
                            sign_out_r <= 1'b0;
                            k_out_r    <= {K_BITS{1'b0}};
                            exp_out_r  <= {ES{1'b0}};
                            frac_out_r <= {FRAC_BITS{1'b0}};
                            zero_out_r <= 1'b0;
                            nar_r      <= 1'b1;
                            done_r     <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            state_r <= SCAN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                SCAN: begin
                    body_r <= {body_r[N-3:0], 1'b0};
                    if (run_s) begin
                        m_r <= m_r + M_BITS'(1'b1);
                        // A run that fills the whole body has no terminator to consume.
                        if (m_r == M_LAST) begin
                            state_r <= EXTRACT;
                        end else begin
                            state_r <= SCAN;
                        end
                    end else begin
                        state_r <= EXTRACT;
                    end
                end

                EXTRACT: begin
                    sign_out_r <= sign_r;
                    k_out_r    <= k_s;
                    exp_out_r  <= body_r[N-2 -: ES];
                    frac_out_r <= body_r[N-2-ES -: FRAC_BITS];
                    zero_out_r <= 1'b0;
                    nar_r      <= 1'b0;
                    done_r     <= 1'b1;
                    state_r    <= DONE;
                end

                DONE: begin
                    if (bus.ready_in) begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end

                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.sign_out = sign_out_r;
    assign bus.k_out    = k_out_r;
    assign bus.exp_out  = exp_out_r;
    assign bus.frac_out = frac_out_r;
    assign bus.zero_out = zero_out_r;
    assign bus.NaR      = nar_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_posit_decoder.sv
// Self-checking bench for posit_decoder: directed vector table, handshake/reset
// sequences, and randomized operands against a bit-position reference model.
module tb_posit_decoder;
    localparam int N         = 32;
    localparam int ES        = 3;
    localparam int K_BITS    = 6;
    localparam int FRAC_BITS = N - ES - 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    posit_decoder_if #(.N(N), .ES(ES), .K_BITS(K_BITS), .FRAC_BITS(FRAC_BITS)) bus ();

    posit_decoder #(.N(N), .ES(ES), .K_BITS(K_BITS), .FRAC_BITS(FRAC_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // lat = clock edges after the start edge until done is seen high
    typedef struct {
        logic [31:0] p;
        logic        s;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [25:0] f;
        logic        z;
        logic        nar;
        int          lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [31:0] p, input logic s, input logic [5:0] k,
                                input logic [2:0] e, input logic [25:0] f, input logic z,
                                input logic nar, input int lat);
        vec_t v;
        v.p = p; v.s = s; v.k = k; v.e = e; v.f = f; v.z = z; v.nar = nar; v.lat = lat;
        return v;
    endfunction

    // Reference: locate the regime run on the magnitude, then read the bits after it.
    function automatic vec_t model(input logic [31:0] p);
        vec_t        v;
        logic [31:0] a;
        logic [30:0] body;
        logic [30:0] rest;
        logic        r0;
        int          m;
        int          k;
        int          used;
        v = mk(p, 1'b0, 6'd0, 3'd0, 26'd0, 1'b0, 1'b0, 0);
        if (p == 32'h0000_0000) begin
            v.z = 1'b1;
        end else if (p == 32'h8000_0000) begin
            v.nar = 1'b1;
        end else begin
            v.s  = p[31];
            a    = p[31] ? (32'h0 - p) : p;
            body = a[30:0];
            r0   = body[30];
            m    = 0;
            while (m < 31 && body[30-m] == r0) m++;
            k    = r0 ? (m - 1) : -m;
            v.k  = 6'(k);
            used = (m == 31) ? 31 : m + 1;
            rest = body << used;
            v.e  = rest[30:28];
            v.f  = rest[27:2];
            v.lat = (m == 31) ? 32 : m + 2;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, done never reached required level", name);
    endtask

    function automatic logic [38:0] outs();
        return {bus.sign_out, bus.k_out, bus.exp_out, bus.frac_out, bus.zero_out, bus.NaR, bus.done};
    endfunction

    task automatic run_op(input logic [31:0] p, output int lat);
        int guard;
        guard = 0;
        while (bus.done === 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 200) bound_fail("done_release");
        @(negedge clk);
        bus.start    = 1'b1;
        bus.posit_in = p;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.posit_in = $urandom;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 100) bound_fail("done_rise");
    endtask

    task automatic check_out(input vec_t v, input int lat, input string tag);
        check({tag, "_sign"}, 64'(bus.sign_out), 64'(v.s));
        check({tag, "_k"},    64'(bus.k_out),    64'(v.k));
        check({tag, "_exp"},  64'(bus.exp_out),  64'(v.e));
        check({tag, "_frac"}, 64'(bus.frac_out), 64'(v.f));
        check({tag, "_zero"}, 64'(bus.zero_out), 64'(v.z));
        check({tag, "_nar"},  64'(bus.NaR),      64'(v.nar));
        check({tag, "_lat"},  64'(lat),          64'(v.lat));
    endtask

    vec_t        tab[13];
    vec_t        v;
    int          lat;
    int          seen;
    logic [38:0] snap;
    logic [31:0] p;

    initial begin
        tab[0]  = mk(32'h0000_0000, 1'b0, 6'h00, 3'd0, 26'h0,       1'b1, 1'b0, 0);
        tab[1]  = mk(32'h4000_0000, 1'b0, 6'h00, 3'd0, 26'h0,       1'b0, 1'b0, 3);
        tab[2]  = mk(32'h4800_0000, 1'b0, 6'h00, 3'd2, 26'h0,       1'b0, 1'b0, 3);
        tab[3]  = mk(32'hC000_0000, 1'b1, 6'h00, 3'd0, 26'h0,       1'b0, 1'b0, 3);
        tab[4]  = mk(32'h7FFF_FFFF, 1'b0, 6'h1E, 3'd0, 26'h0,       1'b0, 1'b0, 32);
        tab[5]  = mk(32'h0000_0001, 1'b0, 6'h22, 3'd0, 26'h0,       1'b0, 1'b0, 32);
        tab[6]  = mk(32'h8000_0000, 1'b0, 6'h00, 3'd0, 26'h0,       1'b0, 1'b1, 0);
        tab[7]  = mk(32'h4C00_0000, 1'b0, 6'h00, 3'd3, 26'h0,       1'b0, 1'b0, 3);
        tab[8]  = mk(32'h4080_0000, 1'b0, 6'h00, 3'd0, 26'h0800000, 1'b0, 1'b0, 3);
        tab[9]  = mk(32'h2000_0000, 1'b0, 6'h3F, 3'd0, 26'h0,       1'b0, 1'b0, 3);
        tab[10] = mk(32'h6000_0000, 1'b0, 6'h01, 3'd0, 26'h0,       1'b0, 1'b0, 4);
        tab[11] = mk(32'hFFFF_FFFF, 1'b1, 6'h22, 3'd0, 26'h0,       1'b0, 1'b0, 32);
        tab[12] = mk(32'h8000_0001, 1'b1, 6'h1E, 3'd0, 26'h0,       1'b0, 1'b0, 32);

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.posit_in = 32'h0;
        bus.ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(tab[i].p, lat);
            check_out(tab[i], lat, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
        end

        // DONE held under ready_in=0; start pulses in DONE must be ignored
        bus.ready_in = 1'b0;
        run_op(32'h4800_0000, lat);
        check_out(tab[2], lat, "hold_entry");
        snap = outs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start    = 1'b1;
            bus.posit_in = 32'h0000_0000;
            @(posedge clk); #1;
            bus.start = 1'b0;
            check($sformatf("hold%0d_outputs", i), 64'(outs()), 64'(snap));
        end
        @(negedge clk);
        bus.ready_in = 1'b1;
        @(posedge clk); #1;
        check("ack_done_fall", 64'(bus.done), 64'd0);
        check("idle_retains_fields", 64'(outs() >> 1), 64'(snap >> 1));
        run_op(32'h4C00_0000, lat);
        check_out(tab[7], lat, "after_ack");
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a long regime scan
        @(negedge clk);
        bus.start    = 1'b1;
        bus.posit_in = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midscan_reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check("no_result_after_abort", 64'(seen), 64'd0);
        run_op(32'h0000_0000, lat);
        check_out(tab[0], lat, "zero_after_reset");
        @(posedge clk); #1;

        for (int i = 0; i < 300; i++) begin
            p = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) p = 32'h0 - p;
            if ($urandom_range(0, 15) == 0) p = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
            v = model(p);
            run_op(p, lat);
            check_out(v, lat, $sformatf("rand%0d_%08h", i, p));
            @(posedge clk); #1;
            check($sformatf("rand%0d_done_pulse", i), 64'(bus.done), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
